muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 212 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring core.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip BUSY.
module muldiv_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_e_i,
    input  logic [2:0]  funct3_e_i,
    input  logic [31:0] src_a_e_i,
    input  logic [31:0] src_b_e_i,
    input  logic        flush_e_i,
    output logic        stall_req_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] src_a_q, src_a_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic        div0_q, div0_d;
    logic [31:0] result_q, result_d;

    logic        accept;
    logic        sgn_a, sgn_b;
    logic        sa, sb;
    logic [31:0] mag_a, mag_b;
    logic        neg_e;
    logic        div0_e;

    logic [32:0] sum33;
    logic [63:0] mul_step;
    logic [32:0] shl;
    logic [32:0] diff;
    logic [63:0] div_step;
    logic [63:0] step;
    logic [63:0] mul_p;
    logic [31:0] div_raw;
    logic [31:0] fin_res;

`ifdef MULDIV_EARLY_OUT_EN
    logic        ovf_e;
    logic [31:0] early_res;
`endif

    assign accept = (state_q == S_IDLE) & start_e_i & ~flush_e_i;

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        unique case (1'b1)
            (funct3_e_i == F_MULH),
            (funct3_e_i == F_DIV),
            (funct3_e_i == F_REM): begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            (funct3_e_i == F_MULHSU): sgn_a = 1'b1;
            default: ;
        endcase
    end

    assign sa    = sgn_a & src_a_e_i[31];
    assign sb    = sgn_b & src_b_e_i[31];
    assign mag_a = sa ? (32'd0 - src_a_e_i) : src_a_e_i;
    assign mag_b = sb ? (32'd0 - src_b_e_i) : src_b_e_i;

    // Remainder follows the dividend; quotient and product follow the XOR.
    assign neg_e  = (funct3_e_i == F_REM) ? sa : (sa ^ sb);
    assign div0_e = funct3_e_i[2] & (src_b_e_i == 32'd0);

`ifdef MULDIV_EARLY_OUT_EN
    assign ovf_e = ((funct3_e_i == F_DIV) | (funct3_e_i == F_REM))
                 & (src_a_e_i == 32'h8000_0000)
                 & (src_b_e_i == 32'hFFFF_FFFF);

    always_comb begin
        early_res = 32'd0;
        unique case (1'b1)
            (div0_e & funct3_e_i[1]):  early_res = src_a_e_i;
            (div0_e & ~funct3_e_i[1]): early_res = 32'hFFFF_FFFF;
            (~div0_e & funct3_e_i[1]): early_res = 32'd0;
            default:                   early_res = 32'h8000_0000;
        endcase
    end
`endif

    // Multiply: acc = {partial, multiplier}, add opnd when LSB set, shift right.
    assign sum33    = {1'b0, acc_q[63:32]}
                    + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    assign mul_step = {sum33, acc_q[31:1]};

    // Divide: acc = {remainder, quotient}, restoring trial subtract.
    assign shl      = acc_q[63:31];
    assign diff     = shl - {1'b0, opnd_q};
    assign div_step = diff[32] ? {shl[31:0], acc_q[30:0], 1'b0}
                               : {diff[31:0], acc_q[30:0], 1'b1};

    assign step = funct3_q[2] ? div_step : mul_step;

    always_comb begin
        mul_p   = neg_q ? (64'd0 - step) : step;
        div_raw = funct3_q[1] ? step[63:32] : step[31:0];
        fin_res = 32'd0;
        unique case (1'b1)
            (~funct3_q[2] & (funct3_q == F_MUL)): fin_res = mul_p[31:0];
            (~funct3_q[2] & (funct3_q != F_MUL)): fin_res = mul_p[63:32];
            (funct3_q[2] & div0_q & funct3_q[1]): fin_res = src_a_q;
            (funct3_q[2] & div0_q & ~funct3_q[1]): fin_res = 32'hFFFF_FFFF;
            default: fin_res = neg_q ? (32'd0 - div_raw) : div_raw;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        src_a_d  = src_a_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_BUSY;
                    cnt_d    = 5'd0;
                    funct3_d = funct3_e_i;
                    src_a_d  = src_a_e_i;
                    neg_d    = neg_e;
                    div0_d   = div0_e;
                    if (funct3_e_i[2]) begin
                        opnd_d = mag_b;
                        acc_d  = {32'd0, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {32'd0, mag_b};
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    if (div0_e | ovf_e) begin
                        state_d  = S_DONE;
                        result_d = early_res;
                    end
`endif
                end
            end
            S_BUSY: begin
                acc_d = step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = S_DONE;
                    result_d = fin_res;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A killed instruction never publishes its result.
        if (flush_e_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            funct3_q <= 3'd0;
            src_a_q  <= 32'd0;
            opnd_q   <= 32'd0;
            acc_q    <= 64'd0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            src_a_q  <= src_a_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            result_q <= result_d;
        end
    end

    assign stall_req_o = ~rst_i & (accept | (state_q == S_BUSY));
    assign busy_o      = (state_q == S_BUSY);
    assign done_o      = (state_q == S_DONE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit.
// Honors MULDIV_EARLY_OUT_EN for expected latency.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_e_i   (start),
        .funct3_e_i  (funct3),
        .src_a_e_i   (src_a),
        .src_b_e_i   (src_b),
        .flush_e_i   (flush),
        .stall_req_o (stall_req),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        longint      la, lb, lu;
        int          sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        la = longint'(sa);
        lb = longint'(sb);
        lu = longint'({32'd0, b});
        model = 32'd0;
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; model = p[31:0]; end
            3'd1: begin p = 64'(la * lb); model = p[63:32]; end
            3'd2: begin p = 64'(la * lu); model = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; model = p[63:32]; end
            3'd4: begin
                if (b == 0) model = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    model = 32'h8000_0000;
                else model = 32'(sa / sb);
            end
            3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) model = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    model = 32'd0;
                else model = 32'(sa % sb);
            end
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
        bit special;
        special = (f[2] && b == 0)
               || ((f == 3'd4 || f == 3'd6)
                   && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_EARLY_OUT_EN
        lat_of = special ? 1 : 33;
`else
        lat_of = special ? 33 : 33;
`endif
    endfunction

    // One full operation: start at cycle T, check stall/done every cycle.
    task automatic do_op(input string tag, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [31:0] e;
        lat = lat_of(f, a, b);
        exp_q.push_back(model(f, a, b));
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = f;
        src_a  = a;
        src_b  = b;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            chk({tag, " stall"}, 32'(stall_req), 32'(k < lat));
            chk({tag, " done"}, 32'(done), 32'(k == lat));
            if (done === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, " result"}, result, e);
                last_res = e;
            end
            if (k == 1) begin
                src_a  = $urandom;
                src_b  = $urandom;
                funct3 = 3'($urandom);
            end
        end
        start = 1'b0;
        chk({tag, " pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " hold"}, result, last_res);
    endtask

    initial begin
        int dcount;
        rst      = 1'b1;
        start    = 1'b1;
        flush    = 1'b0;
        funct3   = 3'd0;
        src_a    = 32'd1;
        src_b    = 32'd1;
        last_res = 32'd0;

        @(negedge clk);
        chk("rst stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", result, 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);

        do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
        chk("mul const", last_res, 32'hFFFF_FFEB);
        do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mulhu const", last_res, 32'hFFFF_FFFE);
        do_op("divu", 3'd5, 32'd100, 32'd7);
        chk("divu const", last_res, 32'd14);
        do_op("remu", 3'd7, 32'd100, 32'd7);
        chk("remu const", last_res, 32'd2);
        do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("div neg", 3'd4, 32'hFFFF_FF9C, 32'd7);
        do_op("rem neg", 3'd6, 32'hFFFF_FF9C, 32'd7);
        do_op("div negb", 3'd4, 32'd100, 32'hFFFF_FFF9);
        do_op("rem negb", 3'd6, 32'd100, 32'hFFFF_FFF9);
        do_op("div0", 3'd4, 32'd5, 32'd0);
        chk("div0 const", last_res, 32'hFFFF_FFFF);
        do_op("remu0", 3'd7, 32'h1234_5678, 32'd0);
        do_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("rem ovf const", last_res, 32'd0);
        do_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div ovf const", last_res, 32'h8000_0000);
        for (int i = 0; i < 4; i++)
            do_op("rand", 3'($urandom), $urandom, $urandom);

        // Flush at T+10 of a DIV.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd4;
        src_a = 32'hFFFF_FF9C; src_b = 32'd7;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("flush pre stall", 32'(stall_req), 32'd1);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush stall", 32'(stall_req), 32'd0);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("flush done", 32'(dcount), 32'd0);
        chk("flush hold", result, last_res);

        // Reset at T+5 of a MULH.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd1;
        src_a = 32'h1234_5678; src_b = 32'h8765_4321;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst op stall", 32'(stall_req), 32'd1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst hold stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post rst busy", 32'(busy), 32'd0);
        chk("post rst stall", 32'(stall_req), 32'd0);
        chk("post rst done", 32'(done), 32'd0);
        chk("post rst result", result, 32'd0);
        last_res = 32'd0;
        dcount = 0;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("post rst no done", 32'(dcount), 32'd0);
        do_op("mul 3x4", 3'd0, 32'd3, 32'd4);
        chk("mul 3x4 const", last_res, 32'd12);

        // Flush and start together in IDLE.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'd0;
        @(negedge clk);
        chk("sf stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("sf busy", 32'(busy), 32'd0);
        chk("sf done", 32'(done), 32'd0);
        chk("sf hold", result, last_res);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
